silife_max7219_rx: RTL and testbench
====================================

SILIFE_MAX7219_RX -- requirements
Module: silife_max7219_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on each serial input (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port spi_sck, input, 1 bit: serial clock from the MAX7219 driver, asynchronous to clk.
REQ-005 SHALL have port spi_mosi, input, 1 bit: serial data, sampled on spi_sck rising edge.
REQ-006 SHALL have port spi_cs_n, input, 1 bit: chip select, active low; rising edge loads the frame.
REQ-007 SHALL have port spi_dout, output, 1 bit: daisy-chain output, equal to shift-register bit 15.
REQ-008 SHALL have port rd_row, input, 3 bits: digit-row select for the read port.
REQ-009 SHALL have port rd_data, output, 8 bits: combinational contents of digit register rd_row+1.
REQ-010 SHALL have ports decode_mode (8), intensity (4), scan_limit (3), shutdown (1), display_test (1), outputs: current control-register values.
REQ-011 SHALL have ports frame_valid (1) and frame_error (1), outputs: single-cycle pulses.
REQ-012 SHALL have ports frame_addr (4) and frame_data (8), outputs: fields of the last valid frame.

Function
REQ-013 SHALL pass spi_sck, spi_mosi and spi_cs_n each through SYNC_STAGES flops; edge detection uses the last two synchronized samples.
REQ-014 SHALL support SCK high and low phases of at least 2 clk cycles each; faster input is out of scope.
REQ-015 SHALL clear the 5-bit bit counter and the 16-bit shift register on a synchronized spi_cs_n falling edge.
REQ-016 SHALL, on each synchronized SCK rising edge while synchronized cs_n is low, shift left with mosi entering bit 0, and increment the counter, saturating at 31.
REQ-017 SHALL ignore SCK edges while cs_n is high.
REQ-018 SHALL ignore an SCK rising edge detected in the same cycle as a cs_n rising edge.
REQ-019 SHALL, on a cs_n rising edge with counter >= 16, decode the shift register as address = bits[11:8] and data = bits[7:0] (the last 16 bits, MAX7219 semantics); bits[15:12] are ignored.
REQ-020 SHALL, on a cs_n rising edge with counter < 16, pulse frame_error for one cycle and change no register.
REQ-021 SHALL decode addresses as: 0x1-0x8 digit rows 0-7; 0x9 decode_mode; 0xA intensity = data[3:0]; 0xB scan_limit = data[2:0]; 0xC shutdown = ~data[0]; 0xF display_test = data[0]; 0x0 and 0xD-0xE no register change.
REQ-022 SHALL update the register and assert frame_valid, frame_addr and frame_data in the cycle immediately after the cs_n rising edge is detected; latency from the edge on the pin is SYNC_STAGES+2 clk cycles.
REQ-023 SHALL assert frame_valid for no-op addresses (0x0, 0xD, 0xE) as well.
REQ-024 SHALL hold frame_addr and frame_data until the next valid frame.
REQ-025 SHALL never assert frame_valid and frame_error in the same cycle.

Reset
REQ-026 SHALL, while reset is high, clear the synchronizers to idle (sck=0, mosi=0, cs_n=1), the counter, the shift register, all digit rows, decode_mode, intensity, scan_limit, display_test, frame_valid, frame_error, frame_addr and frame_data to 0, and set shutdown to 1.
REQ-027 SHALL discard a frame in progress when reset is asserted mid-frame; a cs_n rising edge after reset with fewer than 16 new bits SHALL raise frame_error.

Structure
REQ-028 SHALL place the address constants (NOOP, DIGIT0-DIGIT7, DECODE_MODE, INTENSITY, SCAN_LIMIT, SHUTDOWN, DISPLAY_TEST) in the shared package silife_pkg, where the MAX7219 transmitter also uses them.
REQ-029 SHALL instantiate one sub-module, silife_sync, once per serial input, to build the parameterized synchronizer.

Verification
REQ-030 SHALL verify: send 16 bits 0x0_3A5 (address 3, data 0xA5) -> frame_valid pulse; rd_row=2 reads 0xA5; frame_addr=3.
REQ-031 SHALL verify: send 0x0C01 then 0x0A07 -> shutdown=0, intensity=7, and every other register keeps its reset value.
REQ-032 SHALL verify: send 32 bits 0x0B05_0F01 -> only 0x0F01 is applied (display_test=1, scan_limit stays 0); spi_dout emits 0x0B05 delayed 16 SCK edges.
REQ-033 SHALL verify: send 10 bits then raise cs_n -> frame_error pulse, frame_valid stays 0, and no register changes.
REQ-034 SHALL verify: assert reset after 8 bits of 0x0155, then send 0x0277 -> row 0 = 0x00, row 1 = 0x77, shutdown=1.
REQ-035 SHALL verify: toggle SCK with cs_n high, then send 0x0D33 -> no shift while cs_n is high; frame_valid pulses with frame_addr=0xD and no register changes.

Source files
------------

// File: rtl/silife_pkg.sv
// Shared MAX7219 definitions: register addresses and the control-register bundle,
// used by both the receiver and the transmitter.
package silife_pkg;

   localparam logic [3:0] NOOP         = 4'h0;
   localparam logic [3:0] DIGIT0       = 4'h1;
   localparam logic [3:0] DIGIT1       = 4'h2;
   localparam logic [3:0] DIGIT2       = 4'h3;
   localparam logic [3:0] DIGIT3       = 4'h4;
   localparam logic [3:0] DIGIT4       = 4'h5;
   localparam logic [3:0] DIGIT5       = 4'h6;
   localparam logic [3:0] DIGIT6       = 4'h7;
   localparam logic [3:0] DIGIT7       = 4'h8;
   localparam logic [3:0] DECODE_MODE  = 4'h9;
   localparam logic [3:0] INTENSITY    = 4'hA;
   localparam logic [3:0] SCAN_LIMIT   = 4'hB;
   localparam logic [3:0] SHUTDOWN     = 4'hC;
   localparam logic [3:0] DISPLAY_TEST = 4'hF;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned BITCNT_W   = 5;
   localparam int unsigned NUM_ROWS   = 8;

   typedef struct packed {
      logic [7:0] decode_mode;
      logic [3:0] intensity;
      logic [2:0] scan_limit;
      logic       shutdown;
      logic       display_test;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET = '{
      decode_mode:  8'h00,
      intensity:    4'h0,
      scan_limit:   3'h0,
      shutdown:     1'b1,
      display_test: 1'b0
   };

   function automatic logic is_digit(input logic [3:0] addr);
      return (addr >= DIGIT0) && (addr <= DIGIT7);
   endfunction

endpackage

// File: rtl/silife_sync.sv
// Multi-flop synchronizer for one asynchronous input; reset forces the idle level.
module silife_sync #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

   logic [N-1:0] chain;

   always_ff @(posedge clk) begin
      if (reset) begin
         chain <= {N{RESET_VAL}};
      end else begin
         chain <= {chain[N-2:0], d};
      end
   end

   assign q = chain[N-1];

endmodule

// File: rtl/silife_max7219_rx.sv
// MAX7219-compatible SPI receiver: captures 16-bit frames from an asynchronous
// serial bus and maintains the digit and control registers.
module silife_max7219_rx
   import silife_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_sck,
   input  logic       spi_mosi,
   input  logic       spi_cs_n,
   output logic       spi_dout,
   input  logic [2:0] rd_row,
   output logic [7:0] rd_data,
   output logic [7:0] decode_mode,
   output logic [3:0] intensity,
   output logic [2:0] scan_limit,
   output logic       shutdown,
   output logic       display_test,
   output logic       frame_valid,
   output logic       frame_error,
   output logic [3:0] frame_addr,
   output logic [7:0] frame_data
);

   logic sck_s, mosi_s, cs_s;
   logic sck_p, cs_p;

   silife_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
      .clk(clk), .reset(reset), .d(spi_sck), .q(sck_s)
   );
   silife_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_s)
   );
   silife_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk(clk), .reset(reset), .d(spi_cs_n), .q(cs_s)
   );

   // Edges are registered so every frame event is acted on one cycle after detection.
   logic ev_sck, ev_cs_fall, ev_cs_rise, ev_mosi, ev_cs_low;

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_p      <= 1'b0;
         cs_p       <= 1'b1;
         ev_sck     <= 1'b0;
         ev_cs_fall <= 1'b0;
         ev_cs_rise <= 1'b0;
         ev_mosi    <= 1'b0;
         ev_cs_low  <= 1'b0;
      end else begin
         sck_p      <= sck_s;
         cs_p       <= cs_s;
         ev_sck     <= sck_s & ~sck_p;
         ev_cs_fall <= ~cs_s & cs_p;
         ev_cs_rise <= cs_s & ~cs_p;
         ev_mosi    <= mosi_s;
         ev_cs_low  <= ~cs_s & ~cs_p;
      end
   end

   logic [BITCNT_W-1:0] bit_cnt;
   logic [15:0]         shift_reg;

   always_ff @(posedge clk) begin
      if (reset || ev_cs_fall) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (ev_sck && ev_cs_low && !ev_cs_rise) begin
         shift_reg <= {shift_reg[14:0], ev_mosi};
         if (bit_cnt != '1) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   assign spi_dout = shift_reg[15];

   logic [3:0] dec_addr;
   logic [7:0] dec_data;
   logic [2:0] dec_row;
   logic       frame_ok;

   always_comb begin
      dec_addr = shift_reg[11:8];
      dec_data = shift_reg[7:0];
      dec_row  = 3'(dec_addr - DIGIT0);
      frame_ok = (bit_cnt >= BITCNT_W'(FRAME_BITS));
   end

   logic [7:0] digits [NUM_ROWS];
   ctrl_t      ctrl;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            digits[i] <= '0;
         end
         ctrl        <= CTRL_RESET;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         frame_addr  <= '0;
         frame_data  <= '0;
      end else begin
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         if (ev_cs_rise) begin
            if (frame_ok) begin
               frame_valid <= 1'b1;
               frame_addr  <= dec_addr;
               frame_data  <= dec_data;
               if (is_digit(dec_addr)) begin
                  digits[dec_row] <= dec_data;
               end else begin
                  case (dec_addr)
                     DECODE_MODE:  ctrl.decode_mode  <= dec_data;
                     INTENSITY:    ctrl.intensity    <= dec_data[3:0];
                     SCAN_LIMIT:   ctrl.scan_limit   <= dec_data[2:0];
                     SHUTDOWN:     ctrl.shutdown     <= ~dec_data[0];
                     DISPLAY_TEST: ctrl.display_test <= dec_data[0];
                     default:      ;
                  endcase
               end
            end else begin
               frame_error <= 1'b1;
            end
         end
      end
   end

   assign rd_data      = digits[rd_row];
   assign decode_mode  = ctrl.decode_mode;
   assign intensity    = ctrl.intensity;
   assign scan_limit   = ctrl.scan_limit;
   assign shutdown     = ctrl.shutdown;
   assign display_test = ctrl.display_test;

endmodule

// File: tb/tb_silife_max7219_rx.sv
// Directed and randomized bench for silife_max7219_rx against a frame-level model.
module tb_silife_max7219_rx;

   localparam int unsigned S  = 3;
   localparam int unsigned PH = S + 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       spi_sck, spi_mosi, spi_cs_n;
   logic       spi_dout;
   logic [2:0] rd_row;
   logic [7:0] rd_data;
   logic [7:0] decode_mode;
   logic [3:0] intensity;
   logic [2:0] scan_limit;
   logic       shutdown, display_test;
   logic       frame_valid, frame_error;
   logic [3:0] frame_addr;
   logic [7:0] frame_data;

   silife_max7219_rx #(.SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset),
      .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
      .spi_dout(spi_dout),
      .rd_row(rd_row), .rd_data(rd_data),
      .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
      .shutdown(shutdown), .display_test(display_test),
      .frame_valid(frame_valid), .frame_error(frame_error),
      .frame_addr(frame_addr), .frame_data(frame_data)
   );

   always #5 clk = ~clk;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   // Reference model state
   logic [7:0] m_row [8];
   logic [7:0] m_dm;
   logic [3:0] m_int;
   logic [2:0] m_sl;
   logic       m_sd, m_dt;
   logic [3:0] m_fa;
   logic [7:0] m_fd;
   logic       stream [64];
   int unsigned nbits;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_dout();
      return (nbits >= 16) ? stream[nbits-16] : 1'b0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_row[i] = 8'h00;
      m_dm = 8'h00; m_int = 4'h0; m_sl = 3'h0; m_sd = 1'b1; m_dt = 1'b0;
      m_fa = 4'h0; m_fd = 8'h00;
      nbits = 0;
   endtask

   task automatic model_apply(input logic [3:0] a, input logic [7:0] d);
      m_fa = a; m_fd = d;
      if (a >= 4'd1 && a <= 4'd8) m_row[a-4'd1] = d;
      else if (a == 4'd9)  m_dm = d;
      else if (a == 4'd10) m_int = d[3:0];
      else if (a == 4'd11) m_sl = d[2:0];
      else if (a == 4'd12) m_sd = ~d[0];
      else if (a == 4'd15) m_dt = d[0];
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 8; i++) begin
         rd_row = 3'(i);
         #1;
         check($sformatf("%s_row%0d", tag, i), rd_data, m_row[i]);
      end
      check({tag, "_decode_mode"}, decode_mode, m_dm);
      check({tag, "_intensity"}, intensity, m_int);
      check({tag, "_scan_limit"}, scan_limit, m_sl);
      check({tag, "_shutdown"}, shutdown, m_sd);
      check({tag, "_display_test"}, display_test, m_dt);
      check({tag, "_frame_addr"}, frame_addr, m_fa);
      check({tag, "_frame_data"}, frame_data, m_fd);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      spi_sck = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (PH) @(negedge clk);
   endtask

   task automatic sck_cycle(input logic b);
      spi_mosi = b;
      repeat (PH) @(negedge clk);
      spi_sck = 1'b1;
      repeat (PH) @(negedge clk);
      spi_sck = 1'b0;
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      nbits = 0;
      repeat (PH) @(negedge clk);
   endtask

   task automatic shift_bits(input string tag, input logic [63:0] bits, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         logic b;
         b = bits[n-1-i];
         sck_cycle(b);
         stream[nbits] = b;
         nbits++;
         check($sformatf("%s_dout%0d", tag, nbits), spi_dout, exp_dout());
      end
   endtask

   task automatic close_frame(input string tag);
      int unsigned vcnt, ecnt, both, vlat, elat;
      logic [15:0] word;
      vcnt = 0; ecnt = 0; both = 0; vlat = 0; elat = 0;
      repeat (PH) @(negedge clk);
      spi_cs_n = 1'b1;
      for (int unsigned c = 1; c <= 3 * PH; c++) begin
         @(posedge clk);
         #1;
         if (frame_valid) begin vcnt++; if (vlat == 0) vlat = c; end
         if (frame_error) begin ecnt++; if (elat == 0) elat = c; end
         if (frame_valid && frame_error) both++;
      end
      check({tag, "_both"}, both, 0);
      if (nbits >= 16) begin
         for (int i = 0; i < 16; i++) word[15-i] = stream[nbits-16+i];
         check({tag, "_valid_pulses"}, vcnt, 1);
         check({tag, "_error_pulses"}, ecnt, 0);
         check({tag, "_valid_latency"}, vlat, S + 2);
         model_apply(word[11:8], word[7:0]);
      end else begin
         check({tag, "_valid_pulses"}, vcnt, 0);
         check({tag, "_error_pulses"}, ecnt, 1);
         check({tag, "_error_latency"}, elat, S + 2);
      end
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic send_frame(input string tag, input logic [63:0] bits, input int unsigned n);
      cs_low();
      shift_bits(tag, bits, n);
      close_frame(tag);
   endtask

   initial begin
      int unsigned lens [10] = '{0, 7, 15, 16, 16, 16, 17, 23, 32, 40};
      logic [63:0] rbits;
      int unsigned rlen;
      logic        dout_hold;

      reset = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; rd_row = 3'd0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_frame_valid", frame_valid, 1'b0);
      check("reset_frame_error", frame_error, 1'b0);
      check("reset_dout", spi_dout, 1'b0);
      check_all("reset");
      do_reset();

      // Digit write: address 3 lands in row 2
      send_frame("dig3", 64'h03A5, 16);
      rd_row = 3'd2; #1;
      check("dig3_rd_row2", rd_data, 8'hA5);
      check("dig3_addr", frame_addr, 4'h3);

      do_reset();
      send_frame("shutdown", 64'h0C01, 16);
      send_frame("intensity", 64'h0A07, 16);
      check("ctl_shutdown", shutdown, 1'b0);
      check("ctl_intensity", intensity, 4'h7);

      // 32-bit frame: only the trailing 16 bits take effect
      send_frame("long32", 64'h0B05_0F01, 32);
      check("long32_dt", display_test, 1'b1);
      check("long32_sl", scan_limit, 3'h0);

      send_frame("short10", 64'h2AB, 10);

      // Reset in the middle of a frame
      cs_low();
      shift_bits("midrst_a", 64'h01, 8);
      do_reset();
      nbits = 0;
      shift_bits("midrst_b", 64'h55, 8);
      close_frame("midrst_short");
      send_frame("row1", 64'h0277, 16);
      check("row1_shutdown", shutdown, 1'b1);

      // SCK activity with cs_n high must not shift
      dout_hold = exp_dout();
      for (int i = 0; i < 5; i++) sck_cycle(i[0]);
      check("idle_sck_dout", spi_dout, dout_hold);
      send_frame("noop_d", 64'h0D33, 16);
      check("noop_d_addr", frame_addr, 4'hD);

      for (int r = 0; r < 12; r++) begin
         rlen  = lens[$urandom_range(0, 9)];
         rbits = {$urandom, $urandom};
         send_frame($sformatf("rnd%0d", r), rbits, rlen);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
